// File: rtl/sram_scan_pkg.sv
// Shared definitions for the SRAM address-scan controller.
package sram_scan_pkg;

    // Width of the per-access wait counter (WAIT_CYCLES up to 15)
    localparam int CNT_W = 4;

    // Pass type, latched when a scan is accepted
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/sram_scan_addr_ctr.sv
// Wrapping scan-address counter with a latched end address and last-address compare.
module sram_scan_addr_ctr #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] load_last,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              is_last
);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] last_reg;

    // Next address: load wins over increment; increment wraps naturally at 2^ADDR_W
    always_comb begin
        addr_next = addr_reg;
        if (load) begin
            addr_next = load_addr;
        end else if (inc) begin
            addr_next = addr_reg + ADDR_W'(1);
        end
    end

    // Address and end-address registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg <= '0;
            last_reg <= '0;
        end else begin
            addr_reg <= addr_next;
            if (load) begin
                last_reg <= load_last;
            end
        end
    end

    assign addr    = addr_reg;
    assign is_last = (addr_reg == last_reg);

endmodule

// File: rtl/sram_scan_ctrl.sv
// Address-sequencing SRAM controller: walks an inclusive address range doing a
// write (pattern fill) or read pass. All outputs come straight from flops so the
// SRAM strobes are glitch-free and no input reaches an output combinationally.
module sram_scan_ctrl
    import sram_scan_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] wr_pattern,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               mode_reg, mode_next;
    logic [DATA_W-1:0]  pattern_reg, pattern_next;

    logic               addr_load;
    logic               addr_inc;
    logic               is_last;
    logic               rd_capture;
    logic [ADDR_W-1:0]  addr_next;
    logic [DATA_W-1:0]  addr_ext;

    logic [DATA_W-1:0]  dq_out_reg, dq_out_next;
    logic               dq_oe_reg, dq_oe_next;
    logic               ce_n_reg, ce_n_next;
    logic               we_n_reg, we_n_next;
    logic               oe_n_reg, oe_n_next;
    logic [DATA_W-1:0]  rd_data_reg;
    logic               rd_valid_reg, rd_valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    sram_scan_addr_ctr #(
        .ADDR_W(ADDR_W)
    ) u_addr_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (addr_load),
        .inc      (addr_inc),
        .load_addr(first_addr),
        .load_last(last_addr),
        .addr     (sram_addr),
        .addr_next(addr_next),
        .is_last  (is_last)
    );

    // Zero-extend (or truncate) the upcoming address to the data width for the write pattern
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            if (gi < ADDR_W) begin : g_bit
                assign addr_ext[gi] = addr_next[gi];
            end else begin : g_zero
                assign addr_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // State register plus latched scan parameters and wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            mode_reg    <= MODE_READ;
            pattern_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mode_reg    <= mode_next;
            pattern_reg <= pattern_next;
        end
    end

    // Next-state logic: SETUP, WAIT_CYCLES x ACCESS, HOLD per address, then DONE
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mode_next    = mode_reg;
        pattern_next = pattern_reg;
        addr_load    = 1'b0;
        addr_inc     = 1'b0;
        rd_capture   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_load    = 1'b1;
                    mode_next    = mode;
                    pattern_next = wr_pattern;
                    state_next   = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                state_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_reg == '0) begin
                    rd_capture = (mode_reg == MODE_READ);
                    state_next = S_HOLD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (is_last) begin
                    state_next = S_DONE;
                end else begin
                    addr_inc   = 1'b1;
                    state_next = S_SETUP;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the strobes land on flops
    always_comb begin
        ce_n_next     = 1'b1;
        we_n_next     = 1'b1;
        oe_n_next     = 1'b1;
        dq_oe_next    = 1'b0;
        rd_valid_next = 1'b0;
        done_next     = 1'b0;
        busy_next     = (state_next != S_IDLE);
        dq_out_next   = dq_out_reg;
        case (state_next)
            S_SETUP: begin
                ce_n_next   = 1'b0;
                dq_out_next = pattern_next ^ addr_ext;
                if (mode_next == MODE_WRITE) begin
                    dq_oe_next = 1'b1;
                end else begin
                    oe_n_next = 1'b0;
                end
            end
            S_ACCESS: begin
                ce_n_next = 1'b0;
                if (mode_next == MODE_WRITE) begin
                    dq_oe_next = 1'b1;
                    we_n_next  = 1'b0;
                end else begin
                    oe_n_next = 1'b0;
                end
            end
            S_HOLD: begin
                ce_n_next = 1'b0;
                if (mode_next == MODE_WRITE) begin
                    dq_oe_next = 1'b1;
                end else begin
                    rd_valid_next = 1'b1;
                end
            end
            S_DONE: begin
                done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered SRAM strobes, status flags and captured read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dq_out_reg   <= '0;
            dq_oe_reg    <= 1'b0;
            ce_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            dq_out_reg   <= dq_out_next;
            dq_oe_reg    <= dq_oe_next;
            ce_n_reg     <= ce_n_next;
            we_n_reg     <= we_n_next;
            oe_n_reg     <= oe_n_next;
            rd_valid_reg <= rd_valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            if (rd_capture) begin
                rd_data_reg <= sram_dq_in;
            end
        end
    end

    assign sram_dq_out = dq_out_reg;
    assign sram_dq_oe  = dq_oe_reg;
    assign sram_ce_n   = ce_n_reg;
    assign sram_we_n   = we_n_reg;
    assign sram_oe_n   = oe_n_reg;
    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Scoreboard bench: two builds (WAIT_CYCLES=2 and =1) share stimulus; a monitor
// on the selected build pops expected (address, data) per access.
module tb_sram_scan_ctrl;
    import sram_scan_pkg::*;

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sel;
    logic        mode;
    logic [9:0]  first_addr;
    logic [9:0]  last_addr;
    logic [15:0] wr_pattern;

    logic        start0, start1;
    logic [15:0] dq_in0, dq_in1;
    logic [9:0]  addr0, addr1;
    logic [15:0] dq_out0, dq_out1, rd_data0, rd_data1;
    logic        dq_oe0, dq_oe1, ce_n0, ce_n1, we_n0, we_n1, oe_n0, oe_n1;
    logic        rd_valid0, rd_valid1, busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    // SRAM model: each location reads back as address*3
    assign dq_in0 = 16'(addr0) * 16'd3;
    assign dq_in1 = 16'(addr1) * 16'd3;

    sram_scan_ctrl #(.ADDR_W(10), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode),
        .first_addr(first_addr), .last_addr(last_addr), .wr_pattern(wr_pattern),
        .sram_dq_in(dq_in0), .sram_addr(addr0), .sram_dq_out(dq_out0),
        .sram_dq_oe(dq_oe0), .sram_ce_n(ce_n0), .sram_we_n(we_n0),
        .sram_oe_n(oe_n0), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .busy(busy0), .done(done0)
    );

    sram_scan_ctrl #(.ADDR_W(10), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode),
        .first_addr(first_addr), .last_addr(last_addr), .wr_pattern(wr_pattern),
        .sram_dq_in(dq_in1), .sram_addr(addr1), .sram_dq_out(dq_out1),
        .sram_dq_oe(dq_oe1), .sram_ce_n(ce_n1), .sram_we_n(we_n1),
        .sram_oe_n(oe_n1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .busy(busy1), .done(done1)
    );

    // Monitored view of the selected build
    logic [9:0]  m_addr;
    logic [15:0] m_dq_out, m_rd_data;
    logic        m_dq_oe, m_we_n, m_oe_n, m_rd_valid, m_busy, m_done;
    int          m_w;
    assign m_addr     = sel ? addr1 : addr0;
    assign m_dq_out   = sel ? dq_out1 : dq_out0;
    assign m_rd_data  = sel ? rd_data1 : rd_data0;
    assign m_dq_oe    = sel ? dq_oe1 : dq_oe0;
    assign m_we_n     = sel ? we_n1 : we_n0;
    assign m_oe_n     = sel ? oe_n1 : oe_n0;
    assign m_rd_valid = sel ? rd_valid1 : rd_valid0;
    assign m_busy     = sel ? busy1 : busy0;
    assign m_done     = sel ? done1 : done0;
    assign m_w        = sel ? 1 : 2;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   viol = 0;
    int   cyc = 0;
    int   last_evt = 0;
    bit   have_evt = 1'b0;
    int   we_run = 0;
    bit   prev_we_n = 1'b1;
    bit   prev_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic pop_cmp(input logic [9:0] a, input logic [15:0] d);
        exp_t e;
        $display("acc build=%0d addr=0x%03h data=0x%04h", sel, a, d);
        chk("access_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("access_addr", 32'(a), 32'(e.a));
            chk("access_data", 32'(d), 32'(e.d));
        end
        if (have_evt) chk("cycles_per_addr", 32'(cyc - last_evt), 32'(m_w + 2));
        last_evt = cyc;
        have_evt = 1'b1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (m_busy) busy_cnt++;
            if (prev_done) chk("busy_after_done", 32'(m_busy), 32'd0);
            if (m_done) begin
                done_cnt++;
                chk("done_in_busy", 32'(m_busy), 32'd1);
            end
            prev_done = m_done;
            if (!m_we_n && !m_oe_n) viol++;
            if (mode == MODE_READ && (m_dq_oe || !m_we_n)) viol++;
            if (!m_we_n && prev_we_n) pop_cmp(m_addr, m_dq_out);
            if (!m_we_n) we_run++;
            if (m_we_n && !prev_we_n) begin
                chk("we_low_len", 32'(we_run), 32'(m_w));
                we_run = 0;
            end
            prev_we_n = m_we_n;
            if (m_rd_valid) pop_cmp(m_addr, m_rd_data);
            if (!m_busy) have_evt = 1'b0;
            cyc++;
        end
    end

    task automatic run_scan(input logic s, input logic m, input logic [9:0] f,
                            input logic [9:0] l, input logic [15:0] p, input bit extra);
        int   n, b0, d0, v0;
        logic [9:0] a;
        exp_t e;
        n = (l >= f) ? (int'(l) - int'(f) + 1) : (1024 - int'(f) + int'(l) + 1);
        for (int i = 0; i < n; i++) begin
            a = f + 10'(i);
            e.a = a;
            e.d = (m == MODE_WRITE) ? (p ^ {6'b0, a}) : (16'(a) * 16'd3);
            exp_q.push_back(e);
        end
        b0 = busy_cnt;
        d0 = done_cnt;
        v0 = viol;
        @(posedge clk); #1;
        sel = s; mode = m; first_addr = f; last_addr = l; wr_pattern = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (extra) begin
            @(posedge clk); #1;
            start = 1'b1;
            last_addr = 10'h000;
            wr_pattern = 16'hFFFF;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int g = 0; g < 400; g++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        chk("scan_done_seen", 32'(done_cnt != d0), 32'd1);
        repeat (6) @(posedge clk);
        chk("busy_cycles", 32'(busy_cnt - b0), 32'(n * (m_w + 2) + 1));
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("strobe_rules", 32'(viol - v0), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; sel = 1'b0; mode = MODE_READ;
        first_addr = '0; last_addr = '0; wr_pattern = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_dq_out", 32'(dq_out0), 32'd0);
        chk("rst_dq_oe", 32'(dq_oe0), 32'd0);
        chk("rst_ce_n", 32'(ce_n0), 32'd1);
        chk("rst_we_n", 32'(we_n0), 32'd1);
        chk("rst_oe_n", 32'(oe_n0), 32'd1);
        chk("rst_rd_data", 32'(rd_data0), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);

        // Reset asserted in the middle of a write access
        @(posedge clk); #1;
        reset_n = 1'b1;
        mode = MODE_WRITE; first_addr = 10'h000; last_addr = 10'h003; wr_pattern = 16'hA5A5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int g = 0; g < 20 && we_n0; g++) begin
            @(posedge clk); #1;
        end
        chk("midrst_in_access", 32'(we_n0), 32'd0);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_we_n", 32'(we_n0), 32'd1);
        chk("midrst_ce_n", 32'(ce_n0), 32'd1);
        chk("midrst_dq_oe", 32'(dq_oe0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en = 1'b1;

        run_scan(1'b0, MODE_WRITE, 10'h000, 10'h003, 16'hA5A5, 1'b0);
        run_scan(1'b0, MODE_READ,  10'h010, 10'h012, 16'h0000, 1'b0);
        run_scan(1'b0, MODE_READ,  10'h3FE, 10'h001, 16'h0000, 1'b0);
        run_scan(1'b0, MODE_WRITE, 10'h155, 10'h155, 16'h1234, 1'b1);
        run_scan(1'b1, MODE_WRITE, 10'h000, 10'h001, 16'h5A5A, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
